input_pulse_conditioner: RTL
============================

INPUT_PULSE_CONDITIONER -- requirements
Module: input_pulse_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles of a new level needed to accept it; legal range 1..65535.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 16: clock edges from the first Increase pulse to the first auto-repeat pulse; legal range 2..65535.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 8: clock edges between consecutive auto-repeat pulses; legal range 1..65535.
REQ-004 The block SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port RawIn  input  1  raw asynchronous push-button level; 1 = pressed.
REQ-007 The block SHALL have port RepeatEn  input  1  synchronous auto-repeat enable, sampled every edge.
REQ-008 The block SHALL have port Stable  output  1  debounced registered level of RawIn.
REQ-009 The block SHALL have port Increase  output  1  registered single-cycle pulse, fed directly to the Increase input of the downstream 1-bit counter.

Function
REQ-010 RawIn SHALL pass through a two-flop synchronizer; the second flop output is sync.
REQ-011 The debounce counter SHALL clear on every edge where sync equals Stable, and increment on every edge where they differ.
REQ-012 On the edge where the debounce counter would reach DEBOUNCE_CYCLES, Stable SHALL toggle and the counter SHALL clear instead.
REQ-013 Latency: if RawIn is first sampled high at edge t0 and stays high, Stable SHALL go high after edge t0+DEBOUNCE_CYCLES+1; release has the same latency.
REQ-014 A RawIn excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave Stable and Increase unchanged.
REQ-015 Control FSM states SHALL be IDLE (Stable low), HELD (Stable high, waiting REPEAT_DELAY) and REPEAT (Stable high, pacing at REPEAT_RATE).
REQ-016 On the IDLE->HELD transition (Stable 0->1 edge), Increase SHALL be 1 for exactly that one cycle and the repeat counter SHALL load 0.
REQ-017 In HELD with RepeatEn=1, the repeat counter SHALL increment each edge; REPEAT_DELAY edges after the initial pulse edge, Increase SHALL pulse once, the counter SHALL clear, and the FSM SHALL enter REPEAT.
REQ-018 In REPEAT with RepeatEn=1, Increase SHALL pulse once every REPEAT_RATE edges.
REQ-019 With RepeatEn=0 in HELD or REPEAT, the repeat counter SHALL hold 0, Increase SHALL stay 0, and the FSM SHALL go to or stay in HELD; reasserting RepeatEn restarts the full REPEAT_DELAY wait.
REQ-020 On any Stable 1->0 edge the FSM SHALL go to IDLE with no pulse; if this coincides with a due repeat pulse, the release wins and Increase SHALL be 0.
REQ-021 Increase SHALL never be high on two consecutive cycles for any REPEAT_RATE >= 2 and SHALL never be high while Stable is 0.
REQ-022 The debounce and repeat counters SHALL be 16 bits wide and SHALL never wrap within the legal parameter ranges.

Reset
REQ-023 While Reset=0, both synchronizer flops, both counters, Stable and Increase SHALL be 0 and the FSM SHALL be IDLE, regardless of Clock.
REQ-024 After Reset deasserts with RawIn already high, the block SHALL treat the input as a fresh press and SHALL apply the full REQ-013 latency before Stable and Increase assert.
REQ-025 A Reset assertion mid-hold SHALL cancel any pending repeat pulse immediately.

Verification (defaults D=4, RD=16, RR=8; t0 = first edge sampling RawIn high)
REQ-026 Stimulus: Reset=0 with RawIn toggling. Required response: Stable=0 and Increase=0 throughout.
REQ-027 Stimulus: RawIn high for 3 cycles, then low. Required response: no Increase pulse, Stable stays 0.
REQ-028 Stimulus: RawIn held high for 12 cycles, RepeatEn=0. Required response: exactly one Increase pulse, after edge t0+5; Stable falls 5 edges after release with no pulse.
REQ-029 Stimulus: RawIn held high for 40 cycles, RepeatEn=1. Required response: pulses after edges t0+5, t0+21, t0+29 and t0+37; the due pulse at t0+45 is suppressed because Stable falls on that same edge.
REQ-030 Stimulus: RawIn held high with RepeatEn=1; Reset pulsed low at t0+25, RawIn kept high. Required response: outputs go to 0 at once; the next Increase pulse follows the full 6-edge press latency after Reset releases.
REQ-031 Stimulus: RawIn held high; RepeatEn dropped at t0+15 and raised at t0+30. Required response: only the t0+5 pulse occurs before the drop, and the next pulse occurs 16 edges after RepeatEn is re-sampled high.

Source files
------------

// File: rtl/input_pulse_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press pulse plus auto-repeat pulses.
// Latency: Stable/Increase assert DEBOUNCE_CYCLES+1 edges after RawIn is first sampled high.
// Backpressure: none; Increase is a free-running single-cycle pulse to a downstream counter.
module input_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic RawIn,
    input  logic RepeatEn,
    output logic Stable,
    output logic Increase
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [16:0] LP_DEB = 17'(DEBOUNCE_CYCLES);
    localparam logic [16:0] LP_RD  = 17'(REPEAT_DELAY);
    localparam logic [16:0] LP_RR  = 17'(REPEAT_RATE);

    logic        r_meta;
    logic        r_sync;
    logic        r_stable;
    logic [15:0] r_deb_cnt;
    logic [15:0] r_rep_cnt;
    logic        r_increase;
    logic        r_en_d;
    state_t      r_state;

    logic        w_differ;
    logic [16:0] w_deb_next;
    logic        w_toggle;
    logic        w_rise;
    logic        w_fall;
    logic [16:0] w_rep_next;
    logic [16:0] w_rep_limit;
    logic        w_rep_due;

    // Counters are compared one bit wider so the +1 never aliases at 65535.
    assign w_differ    = r_sync ^ r_stable;
    assign w_deb_next  = {1'b0, r_deb_cnt} + 17'd1;
    assign w_toggle    = w_differ && (w_deb_next == LP_DEB);
    assign w_rise      = w_toggle && !r_stable;
    assign w_fall      = w_toggle && r_stable;
    assign w_rep_next  = {1'b0, r_rep_cnt} + 17'd1;
    assign w_rep_limit = (r_state == ST_HELD) ? LP_RD : LP_RR;
    assign w_rep_due   = (w_rep_next == w_rep_limit);

    assign Stable   = r_stable;
    assign Increase = r_increase;

    // Synchronize RawIn and accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_stable  <= 1'b0;
            r_deb_cnt <= 16'd0;
        end else begin
            r_meta <= RawIn;
            r_sync <= r_meta;
            if (!w_differ) begin
                r_deb_cnt <= 16'd0;
            end else if (w_toggle) begin
                r_deb_cnt <= 16'd0;
                r_stable  <= ~r_stable;
            end else begin
                r_deb_cnt <= w_deb_next[15:0];
            end
        end
    end

    // Press/repeat FSM: pulse on press, after REPEAT_DELAY, then every REPEAT_RATE; release wins.
    // The edge on which RepeatEn is first seen high again is treated like the press edge,
    // so a re-enabled wait is a full REPEAT_DELAY edges after that edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_rep_cnt  <= 16'd0;
            r_increase <= 1'b0;
            r_en_d     <= 1'b0;
        end else begin
            r_en_d <= RepeatEn;
            case (r_state)
                ST_IDLE: begin
                    r_rep_cnt <= 16'd0;
                    if (w_rise) begin
                        r_state    <= ST_HELD;
                        r_increase <= 1'b1;
                    end else begin
                        r_increase <= 1'b0;
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    if (w_fall) begin
                        r_state    <= ST_IDLE;
                        r_rep_cnt  <= 16'd0;
                        r_increase <= 1'b0;
                    end else if (!RepeatEn || !r_en_d) begin
                        r_state    <= ST_HELD;
                        r_rep_cnt  <= 16'd0;
                        r_increase <= 1'b0;
                    end else if (w_rep_due) begin
                        r_state    <= ST_REPEAT;
                        r_rep_cnt  <= 16'd0;
                        r_increase <= 1'b1;
                    end else begin
                        r_rep_cnt  <= w_rep_next[15:0];
                        r_increase <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rep_cnt  <= 16'd0;
                    r_increase <= 1'b0;
                end
            endcase
        end
    end

endmodule
